mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one 2:1 mux output channel between two requesters.
//  Picks a winner, drives the mux select, and inserts break-before-make turnaround cycles when
//  the select changes. Caps each grant at MAX_BURST accepted beats so neither side starves.
//  Sits between two sources and a single valid/ready sink.
// PARAMETERS
//  WIDTH       8   data width of each requester and of out_data
//  MAX_BURST   4   max accepted beats per grant (legal range >= 1)
//  TURNAROUND  1   idle cycles after a select change before data flows (legal range >= 0)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  req0       in   1      requester 0 wants the channel; held high for the whole transaction
//  req1       in   1      requester 1 wants the channel
//  data0      in   WIDTH  requester 0 data
//  data1      in   WIDTH  requester 1 data
//  gnt0       out  1      registered grant to requester 0
//  gnt1       out  1      registered grant to requester 1
//  sel        out  1      registered mux select: 0 = data0, 1 = data1
//  out_data   out  WIDTH  sel ? data1 : data0 (combinational)
//  out_valid  out  1      beat offered to the sink
//  out_ready  in   1      sink accepts a beat when out_valid && out_ready
//  busy       out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, sel=0, gnt0=gnt1=0, out_valid=0, busy=0, beat_cnt=0, turn_cnt=0.
//   - last=1, so req0 wins the first tie.
//   - Takes effect mid-transfer: all outputs return to reset values at once and the beat is dropped.
//  States: IDLE, TURN, GRANT. Winner index w is registered.
//  IDLE
//   - No request: stay in IDLE.
//   - Choosing w: only one req high -> that side; both high -> w = ~last.
//   - w == sel: go to GRANT next cycle.
//   - w != sel: sel <= w next edge; then go to GRANT if TURNAROUND == 0, else go to TURN
//     with turn_cnt=0.
//  TURN
//   - gnt0=gnt1=0, out_valid=0; turn_cnt increments each cycle.
//   - After TURNAROUND cycles: GRANT.
//   - req_w drops during TURN: back to IDLE next cycle; sel is kept and last is unchanged.
//  GRANT
//   - gnt_w=1, the other gnt=0. out_valid = req_w (combinational).
//   - Each accepted beat increments beat_cnt.
//   - Exit to IDLE (gnt low next cycle, beat_cnt <= 0, last <= w) when either holds:
//     req_w == 0, or a beat is accepted with beat_cnt == MAX_BURST-1.
//  Latency
//   - Request from IDLE with matching sel: gnt and out_valid are high 1 cycle after req is sampled.
//   - Select change: add 1 + TURNAROUND cycles.
//  Boundary conditions
//   - A loser's request is never lost; it waits with gnt low.
//   - After a burst-limit exit with both req high, the other side wins the next arbitration.
//   - A lone requester may be regranted back-to-back, with one IDLE cycle between grants.
//   - out_ready low stalls: beat_cnt, gnt and sel hold.
//   - gnt0 and gnt1 are never both high.
//   - sel never changes while out_valid=1.
// TESTING
//  1. Reset, then req0=1, data0=8'hA5, out_ready=1 -> 1 cycle later gnt0=1, sel=0, out_valid=1,
//     out_data=A5; after 4 beats gnt0 falls and the next grant is 1 cycle later.
//  2. req1 alone from reset, TURNAROUND=1 -> sel=1 next cycle; 1 TURN cycle with out_valid=0;
//     gnt1=1 on cycle 3; out_data=data1.
//  3. req0=req1=1 held 40 cycles, out_ready=1 -> grants alternate 0,1,0,1, each exactly
//     4 beats, with a turnaround gap between each.
//  4. Grant 0 active, out_ready=0 for 5 cycles -> out_valid stays 1, beat_cnt frozen,
//     sel unchanged; the burst completes after out_ready returns.
//  5. req1 dropped during TURN -> IDLE next cycle, gnt1 never asserts, sel stays 1.
//  6. rst_n pulsed low mid-burst -> gnt/out_valid/busy go 0 immediately and sel=0;
//     after release a tie goes to req0.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin sequencer sharing one 2:1 mux output channel
// Break-before-make select changes, burst-capped grants, valid/ready sink side.
module mux2_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          w, w_n;
  logic          last, last_n;
  logic          sel_n;
  logic          pend, pend_n;
  logic          gnt0_n, gnt1_n;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [TW-1:0] turn_cnt, turn_n;
  logic          req_w;
  logic          pick;
  logic          accept;

  assign req_w    = w ? req1 : req0;
  assign pick     = (req0 && req1) ? ~last : req1;
  assign out_data = sel ? data1 : data0;
  assign out_valid = (state == GRANT) && req_w;
  assign accept   = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w        <= 1'b0;
      last     <= 1'b1;
      sel      <= 1'b0;
      pend     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      beat_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_n;
      w        <= w_n;
      last     <= last_n;
      sel      <= sel_n;
      pend     <= pend_n;
      gnt0     <= gnt0_n;
      gnt1     <= gnt1_n;
      beat_cnt <= beat_n;
      turn_cnt <= turn_n;
    end
  end

  // pend marks the IDLE cycle right after sel moved: the mux output settles
  // before the turnaround window (if any) starts counting.
  always_comb begin
    state_n = state;
    w_n     = w;
    last_n  = last;
    sel_n   = sel;
    pend_n  = pend;
    beat_n  = beat_cnt;
    turn_n  = turn_cnt;
    case (state)
      IDLE: begin
        if (pend) begin
          pend_n = 1'b0;
          if (req_w) begin
            turn_n = '0;
            if (TURNAROUND == 0) state_n = GRANT;
            else                 state_n = TURN;
          end
        end else if (req0 || req1) begin
          w_n = pick;
          if (pick == sel) begin
            state_n = GRANT;
          end else begin
            sel_n  = pick;
            pend_n = 1'b1;
          end
        end
      end
      TURN: begin
        if (!req_w) begin
          state_n = IDLE;
        end else if (turn_cnt == TURN_LAST) begin
          state_n = GRANT;
          turn_n  = '0;
        end else begin
          turn_n = turn_cnt + 1'b1;
        end
      end
      GRANT: begin
        if (!req_w || (accept && (beat_cnt == BEAT_LAST))) begin
          state_n = IDLE;
          beat_n  = '0;
          last_n  = w;
        end else if (accept) begin
          beat_n = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        pend_n  = 1'b0;
        beat_n  = '0;
        turn_n  = '0;
      end
    endcase
    gnt0_n = (state_n == GRANT) && !w_n;
    gnt1_n = (state_n == GRANT) &&  w_n;
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed self-checking bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, sel, out_valid, out_ready, busy;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .TURNAROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, sel, out_valid, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state got {gnt0,gnt1,sel,vld,busy}=%b want 00000", {gnt0, gnt1, sel, out_valid, busy});
    end
  endtask

  task automatic test_lone_req0();
    do_reset();
    req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, sel, out_valid, out_data} !== {4'b1001, 8'hA5}) begin
        errors++;
        $display("FAIL lone0_beat%0d got {g0,g1,sel,vld,data}=%b_%h want 1001_a5", i, {gnt0, gnt1, sel, out_valid}, out_data);
      end
    end
    @(negedge clk);
    checks++;
    if ({gnt0, busy} !== 2'b00) begin
      errors++;
      $display("FAIL lone0_gap got {gnt0,busy}=%b want 00", {gnt0, busy});
    end
    @(negedge clk);
    checks++;
    if ({gnt0, out_valid} !== 2'b11) begin
      errors++;
      $display("FAIL lone0_regrant got {gnt0,vld}=%b want 11", {gnt0, out_valid});
    end
    req0 = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lone0_drop_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_lone_req1();
    do_reset();
    req1 = 1'b1; data0 = 8'h00; data1 = 8'h3C; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel, gnt1, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL req1_cycle1 got {sel,gnt1,vld}=%b want 100", {sel, gnt1, out_valid});
    end
    @(negedge clk);
    checks++;
    if ({sel, gnt1, out_valid, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL req1_turn got {sel,gnt1,vld,busy}=%b want 1001", {sel, gnt1, out_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({sel, gnt0, gnt1, out_valid, out_data} !== {4'b1011, 8'h3C}) begin
      errors++;
      $display("FAIL req1_grant got {sel,g0,g1,vld,data}=%b_%h want 1011_3c", {sel, gnt0, gnt1, out_valid}, out_data);
    end
  endtask

  task automatic test_round_robin();
    int n_grants = 0;
    int sides[$];
    int starts[$];
    int beats = 0;
    int bad_beats = 0;
    int overlap = 0;
    int sel_glitch = 0;
    logic prev_g = 1'b0;
    logic prev_sel = 1'b0;
    logic prev_vld = 1'b0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; out_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) overlap++;
      if ((sel !== prev_sel) && prev_vld) sel_glitch++;
      if ((gnt0 || gnt1) && !prev_g) begin
        n_grants++;
        sides.push_back(gnt1 ? 1 : 0);
        starts.push_back(c);
        beats = 0;
      end
      if (!(gnt0 || gnt1) && prev_g && (beats != 4)) bad_beats++;
      if (out_valid && out_ready) beats++;
      prev_g = gnt0 || gnt1; prev_sel = sel; prev_vld = out_valid;
    end
    checks++;
    if (n_grants != 6) begin
      errors++;
      $display("FAIL rr_grant_count got %0d want 6", n_grants);
    end
    for (int i = 0; i < n_grants && i < 6; i++) begin
      checks++;
      if (sides[i] != (i % 2) || starts[i] != 1 + 7 * i) begin
        errors++;
        $display("FAIL rr_grant%0d got side %0d at cycle %0d want side %0d at cycle %0d", i, sides[i], starts[i], i % 2, 1 + 7 * i);
      end
    end
    checks++;
    if (bad_beats != 0 || overlap != 0 || sel_glitch != 0) begin
      errors++;
      $display("FAIL rr_invariants got bad_bursts=%0d overlap=%0d sel_glitch=%0d want 0 0 0", bad_beats, overlap, sel_glitch);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req0 = 1'b1; data0 = 8'h5A; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, sel, out_valid} !== 3'b101) begin
        errors++;
        $display("FAIL stall%0d got {gnt0,sel,vld}=%b want 101", i, {gnt0, sel, out_valid});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume got gnt0=%b want 1", gnt0);
    end
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_burst_end got gnt0=%b want 0", gnt0);
    end
  endtask

  task automatic test_turn_drop();
    do_reset();
    req1 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, gnt1, sel} !== 3'b001) begin
        errors++;
        $display("FAIL turn_drop%0d got {busy,gnt1,sel}=%b want 001", i, {busy, gnt1, sel});
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; out_ready = 1'b1;
    repeat (9) @(negedge clk);
    checks++;
    if ({gnt1, sel, out_data} !== {2'b11, 8'h22}) begin
      errors++;
      $display("FAIL arst_pre got {gnt1,sel,data}=%b_%h want 11_22", {gnt1, sel}, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, sel, out_valid, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL arst_immediate got {g0,g1,sel,vld,busy}=%b want 00000", {gnt0, gnt1, sel, out_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, sel, out_data} !== {3'b100, 8'h11}) begin
      errors++;
      $display("FAIL arst_tie got {g0,g1,sel,data}=%b_%h want 100_11", {gnt0, gnt1, sel}, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_lone_req0();
    test_lone_req1();
    test_round_robin();
    test_stall();
    test_turn_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
